// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array input feeder.
package sa_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/sa_input_feeder_if.sv
// Control, vector-stream and PE-row bundle of the input feeder.
// Optional bubble_cnt signal exists only when SA_FEEDER_PERF_CNT_EN is defined.
interface sa_input_feeder_if
  import sa_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned TILE_LEN_W = 16
);

  logic                  start;
  logic [TILE_LEN_W-1:0] tile_len;
  logic                  busy;
  logic                  done;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_data;
  logic [N*DATA_W-1:0]   row_input;
  logic [N-1:0]          row_valid;
  logic [N-1:0]          row_switch;
`ifdef SA_FEEDER_PERF_CNT_EN
  logic [31:0]           bubble_cnt;
`endif

`ifdef SA_FEEDER_PERF_CNT_EN
  modport master (
    output start, tile_len, in_valid, in_data,
    input  busy, done, in_ready, row_input, row_valid, row_switch, bubble_cnt
  );
  modport slave (
    input  start, tile_len, in_valid, in_data,
    output busy, done, in_ready, row_input, row_valid, row_switch, bubble_cnt
  );
`else
  modport master (
    output start, tile_len, in_valid, in_data,
    input  busy, done, in_ready, row_input, row_valid, row_switch
  );
  modport slave (
    input  start, tile_len, in_valid, in_data,
    output busy, done, in_ready, row_input, row_valid, row_switch
  );
`endif

endinterface

// File: rtl/sa_skew_delay.sv
// Zero-reset shift register; DEPTH cycles of latency for one row's {switch,valid,data}.
module sa_skew_delay #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/sa_input_feeder.sv
// West-edge feeder: skews activation vectors diagonally into PE rows, preceded by a switch wavefront.
// Optional bubble counter enabled by defining SA_FEEDER_PERF_CNT_EN.
module sa_input_feeder
  import sa_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned TILE_LEN_W = 16
) (
  input logic              clk,
  input logic              rst,
  sa_input_feeder_if.slave bus
);

  localparam int unsigned DRAIN_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SLOT_W  = DATA_W + 2;

  feeder_state_t         state;
  feeder_state_t         state_nxt;
  logic [TILE_LEN_W-1:0] len_q;
  logic [TILE_LEN_W-1:0] acc_cnt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  busy_q;
  logic                  done_q;

  logic start_ok;
  logic accept;
  logic last_accept;
  logic drain_last;
  logic switch_slot;

  assign start_ok    = (state == IDLE) && bus.start;
  assign accept      = (state == STREAM) && bus.in_valid;
  assign last_accept = accept && ((acc_cnt + TILE_LEN_W'(1)) == len_q);
  assign drain_last  = (drain_cnt == DRAIN_W'(N - 1));
  assign switch_slot = (state == SWITCH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SWITCH;
      SWITCH:  state_nxt = (len_q == '0) ? DRAIN : STREAM;
      STREAM:  if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tile length, accept and drain counters, status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      acc_cnt   <= '0;
      drain_cnt <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q   <= bus.tile_len;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + TILE_LEN_W'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state == DRAIN) && drain_last;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.in_ready = (state == STREAM);

`ifdef SA_FEEDER_PERF_CNT_EN
  logic [31:0] bubble_q;

  // Saturating count of STREAM cycles starved by upstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (start_ok) begin
      bubble_q <= '0;
    end else if ((state == STREAM) && !bus.in_valid && (bubble_q != '1)) begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign bus.bubble_cnt = bubble_q;
`endif

  logic [N-1:0]        row_sw;
  logic [N-1:0]        row_vld;
  logic [N*DATA_W-1:0] row_dat;

  // Row r delayed by r+1 cycles; unaccepted slots carry zero data
  for (genvar r = 0; r < N; r++) begin : g_row
    logic [DATA_W-1:0] lane;
    logic [SLOT_W-1:0] slot_d;
    logic [SLOT_W-1:0] slot_q;

    assign lane   = accept ? bus.in_data[r*DATA_W +: DATA_W] : '0;
    assign slot_d = {switch_slot, accept, lane};

    sa_skew_delay #(
      .WIDTH (SLOT_W),
      .DEPTH (r + 1)
    ) u_skew (
      .clk (clk),
      .rst (rst),
      .d   (slot_d),
      .q   (slot_q)
    );

    assign row_sw[r]                   = slot_q[SLOT_W-1];
    assign row_vld[r]                  = slot_q[DATA_W];
    assign row_dat[r*DATA_W +: DATA_W] = slot_q[DATA_W-1:0];
  end

  assign bus.row_switch = row_sw;
  assign bus.row_valid  = row_vld;
  assign bus.row_input  = row_dat;

endmodule
